// File: rtl/c17_bist_pkg.sv
// -----------------------------------------------------------------------------
// c17_bist_pkg
// Shared constants for the c17 BIST controller: datapath widths, default
// LFSR seed / MISR polynomial, and the controller state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package c17_bist_pkg;

  localparam int unsigned LFSR_W = 5;
  localparam int unsigned MISR_W = 8;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED      = 5'b00001;
  localparam logic [MISR_W-1:0] DEFAULT_MISR_POLY = 8'h1D;

  // Controller states: IDLE, RUN, DONE
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/c17_bist_ctrl_c17.sv
// -----------------------------------------------------------------------------
// c17_bist_ctrl_c17
// ISCAS-85 c17 benchmark netlist: six 2-input NAND gates, purely combinational.
// Ports:
//   i_g1, i_g2, i_g3, i_g6, i_g7  in   primary inputs G1..G7
//   o_g22, o_g23                  out  primary outputs G22, G23
// -----------------------------------------------------------------------------
module c17_bist_ctrl_c17 (
  input  logic i_g1,
  input  logic i_g2,
  input  logic i_g3,
  input  logic i_g6,
  input  logic i_g7,
  output logic o_g22,
  output logic o_g23
);

  logic w_g10;
  logic w_g11;
  logic w_g16;
  logic w_g19;

  assign w_g10 = ~(i_g1 & i_g3);
  assign w_g11 = ~(i_g3 & i_g6);
  assign w_g16 = ~(i_g2 & w_g11);
  assign w_g19 = ~(w_g11 & i_g7);
  assign o_g22 = ~(w_g10 & w_g16);
  assign o_g23 = ~(w_g16 & w_g19);

endmodule

// File: rtl/c17_bist_ctrl.sv
// -----------------------------------------------------------------------------
// c17_bist_ctrl
// BIST harness for the c17 netlist. A 5-bit LFSR (x^5+x^3+1) drives the c17
// inputs, G23/G22 are compacted into an 8-bit MISR, and the final signature is
// compared against a golden value at the end of the run.
// Parameters:
//   NUM_PATTERNS  patterns applied per run (1..31)
//   SEED          nonzero LFSR load value
//   MISR_POLY     MISR feedback taps, XORed in when misr[7] is set
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset
//   start      in   begins a run from IDLE or DONE; ignored during RUN
//   golden     in   expected signature, sampled on the RUN->DONE edge
//   busy       out  high in RUN
//   done       out  high in DONE
//   pass       out  signature matched golden (valid while done)
//   signature  out  current MISR contents
//   pattern    out  current LFSR value = {G1,G2,G3,G6,G7}
// -----------------------------------------------------------------------------
module c17_bist_ctrl
  import c17_bist_pkg::*;
#(
  parameter int unsigned        NUM_PATTERNS = 31,
  parameter logic [LFSR_W-1:0]  SEED         = DEFAULT_SEED,
  parameter logic [MISR_W-1:0]  MISR_POLY    = DEFAULT_MISR_POLY
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [MISR_W-1:0] golden,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature,
  output logic [LFSR_W-1:0] pattern
);

  localparam logic [LFSR_W-1:0] LAST_COUNT = LFSR_W'(NUM_PATTERNS - 1);

  logic [1:0]        r_state;
  logic [LFSR_W-1:0] r_lfsr;
  logic [MISR_W-1:0] r_misr;
  logic [LFSR_W-1:0] r_count;
  logic              r_pass;

  logic              w_g22;
  logic              w_g23;
  logic [LFSR_W-1:0] w_lfsr_next;
  logic [MISR_W-1:0] w_misr_next;

  c17_bist_ctrl_c17 u_c17 (
    .i_g1  (r_lfsr[4]),
    .i_g2  (r_lfsr[3]),
    .i_g3  (r_lfsr[2]),
    .i_g6  (r_lfsr[1]),
    .i_g7  (r_lfsr[0]),
    .o_g22 (w_g22),
    .o_g23 (w_g23)
  );

  assign w_lfsr_next = {r_lfsr[LFSR_W-2:0], r_lfsr[4] ^ r_lfsr[2]};
  assign w_misr_next = {r_misr[MISR_W-2:0], 1'b0}
                     ^ (r_misr[MISR_W-1] ? MISR_POLY : '0)
                     ^ {{(MISR_W-2){1'b0}}, w_g23, w_g22};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_lfsr  <= SEED;
      r_misr  <= '0;
      r_count <= '0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_RUN;
            r_lfsr  <= SEED;
            r_misr  <= '0;
            r_count <= '0;
            r_pass  <= 1'b0;
          end
        end
        S_RUN: begin
          r_lfsr  <= w_lfsr_next;
          r_misr  <= w_misr_next;
          r_count <= r_count + 1'b1;
          // Last capture: compare the signature being written this edge.
          if (r_count == LAST_COUNT) begin
            r_state <= S_DONE;
            r_pass  <= (w_misr_next == golden);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign pass      = r_pass;
  assign signature = r_misr;
  assign pattern   = r_lfsr;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
module tb_c17_bist_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A: default 31-pattern run
  logic       reset_a, start_a;
  logic [7:0] golden_a;
  logic       busy_a, done_a, pass_a;
  logic [7:0] sig_a;
  logic [4:0] pat_a;

  // Instance B: 4-pattern run
  logic       reset_b, start_b;
  logic [7:0] golden_b;
  logic       busy_b, done_b, pass_b;
  logic [7:0] sig_b;
  logic [4:0] pat_b;

  c17_bist_ctrl u_dut31 (
    .clock     (clock),
    .reset     (reset_a),
    .start     (start_a),
    .golden    (golden_a),
    .busy      (busy_a),
    .done      (done_a),
    .pass      (pass_a),
    .signature (sig_a),
    .pattern   (pat_a)
  );

  c17_bist_ctrl #(.NUM_PATTERNS(4)) u_dut4 (
    .clock     (clock),
    .reset     (reset_b),
    .start     (start_b),
    .golden    (golden_b),
    .busy      (busy_b),
    .done      (done_b),
    .pass      (pass_b),
    .signature (sig_b),
    .pattern   (pat_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // c17 outputs written as sum-of-products of the primary inputs.
  function automatic int c17_model(input int p);
    int g1, g2, g3, g6, g7, g22, g23;
    g1 = (p >> 4) & 1; g2 = (p >> 3) & 1; g3 = (p >> 2) & 1;
    g6 = (p >> 1) & 1; g7 = p & 1;
    g22 = (g1 & g3) | (g2 & (1 - (g3 & g6)));
    g23 = (1 - (g3 & g6)) & (g2 | g7);
    return g23 * 2 + g22;
  endfunction

  function automatic int next_pattern(input int p);
    return ((p * 2) % 32) + (((p >> 4) ^ (p >> 2)) & 1);
  endfunction

  function automatic logic [7:0] sig_model(input int n);
    int p, s;
    p = 1;
    s = 0;
    for (int i = 0; i < n; i++) begin
      s = ((s * 2) % 256) ^ ((s >= 128) ? 'h1D : 0) ^ c17_model(p);
      p = next_pattern(p);
    end
    return 8'(s);
  endfunction

  typedef struct {
    logic [7:0] golden;
    int         glitch_edge;  // edge in RUN where start is pulsed again; 0 = none
    logic       exp_pass;
    logic [7:0] exp_sig;
  } vec_t;

  vec_t vecs[4];

  // Start at edge 0 (driven just after it, sampled by edge 1); busy after
  // edges 1..4, done after edge 5.
  task automatic run4(input logic [7:0] gold, input int glitch, input logic exp_pass,
                      input logic [7:0] exp_sig, input string tag);
    golden_b = gold;
    start_b  = 1'b1;
    tick();
    start_b  = 1'b0;
    check({tag, " first_pattern"}, 32'(pat_b), 32'h01);
    for (int e = 1; e <= 4; e++) begin
      check({tag, " busy"}, 32'(busy_b), 32'h1);
      check({tag, " done_low"}, 32'(done_b), 32'h0);
      start_b = (e == glitch);
      tick();
      start_b = 1'b0;
    end
    check({tag, " busy_low"}, 32'(busy_b), 32'h0);
    check({tag, " done"}, 32'(done_b), 32'h1);
    check({tag, " pass"}, 32'(pass_b), 32'(exp_pass));
    check({tag, " signature"}, 32'(sig_b), 32'(exp_sig));
    // golden no longer matters once DONE is reached
    golden_b = ~gold;
    tick();
    check({tag, " pass_hold"}, 32'(pass_b), 32'(exp_pass));
    check({tag, " sig_hold"}, 32'(sig_b), 32'(exp_sig));
  endtask

  initial begin
    logic [4:0]  pat_tab [6];
    logic [7:0]  sig_tab [4];
    logic [31:0] seen;
    int          dup;
    logic [7:0]  model4;

    pat_tab = '{5'b00001, 5'b00010, 5'b00100, 5'b01001, 5'b10010, 5'b00101};
    sig_tab = '{8'h02, 8'h04, 8'h08, 8'h13};
    vecs[0] = '{golden: 8'h13, glitch_edge: 0, exp_pass: 1'b1, exp_sig: 8'h13};
    vecs[1] = '{golden: 8'h12, glitch_edge: 0, exp_pass: 1'b0, exp_sig: 8'h13};
    vecs[2] = '{golden: 8'h13, glitch_edge: 2, exp_pass: 1'b1, exp_sig: 8'h13};
    vecs[3] = '{golden: 8'h00, glitch_edge: 4, exp_pass: 1'b0, exp_sig: 8'h13};
    model4 = sig_model(4);

    reset_a = 1'b1; start_a = 1'b0; golden_a = 8'h00;
    reset_b = 1'b1; start_b = 1'b0; golden_b = 8'h00;
    tick();
    tick();
    reset_a = 1'b0;
    reset_b = 1'b0;

    check("rst busy", 32'(busy_a), 32'h0);
    check("rst done", 32'(done_a), 32'h0);
    check("rst pass", 32'(pass_a), 32'h0);
    check("rst sig", 32'(sig_a), 32'h0);
    check("rst pattern", 32'(pat_a), 32'h01);
    check("rst4 pattern", 32'(pat_b), 32'h01);
    check("rst4 busy", 32'(busy_b), 32'h0);

    // Full 31-pattern run
    golden_a = sig_model(31);
    start_a  = 1'b1;
    tick();
    start_a  = 1'b0;
    seen = '0;
    dup  = 0;
    for (int k = 0; k < 31; k++) begin
      check("full busy", 32'(busy_a), 32'h1);
      if (k < 6) check($sformatf("full pattern[%0d]", k), 32'(pat_a), 32'(pat_tab[k]));
      if (k >= 1 && k <= 4)
        check($sformatf("full sig[%0d]", k), 32'(sig_a), 32'(sig_tab[k-1]));
      if (seen[pat_a]) dup++;
      seen[pat_a] = 1'b1;
      tick();
    end
    check("full done", 32'(done_a), 32'h1);
    check("full pass", 32'(pass_a), 32'h1);
    check("full sig", 32'(sig_a), 32'(sig_model(31)));
    check("full coverage", seen, 32'hFFFF_FFFE);
    check("full duplicates", 32'(dup), 32'h0);

    // Restart from DONE
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("restart done", 32'(done_a), 32'h0);
    check("restart busy", 32'(busy_a), 32'h1);
    check("restart sig", 32'(sig_a), 32'h0);
    check("restart pattern", 32'(pat_a), 32'h01);

    // Table-driven 4-pattern runs
    for (int i = 0; i < 4; i++)
      run4(vecs[i].golden, vecs[i].glitch_edge, vecs[i].exp_pass, vecs[i].exp_sig,
           $sformatf("vec%0d", i));

    // Reset mid-run aborts the run
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick();
    tick();
    reset_b = 1'b1;
    tick();
    reset_b = 1'b0;
    check("midrst busy", 32'(busy_b), 32'h0);
    check("midrst done", 32'(done_b), 32'h0);
    check("midrst pass", 32'(pass_b), 32'h0);
    check("midrst sig", 32'(sig_b), 32'h0);
    check("midrst pattern", 32'(pat_b), 32'h01);
    tick();
    check("midrst stays idle", 32'(busy_b | done_b), 32'h0);
    run4(8'h13, 0, 1'b1, 8'h13, "after_reset");

    // Randomized runs against the model
    for (int r = 0; r < 16; r++) begin
      logic [7:0] gold;
      int         glitch;
      int         idle;
      gold   = ($urandom_range(0, 1) == 1) ? model4 : 8'($urandom);
      glitch = $urandom_range(0, 4);
      idle   = $urandom_range(0, 3);
      for (int j = 0; j < idle; j++) tick();
      run4(gold, glitch, (gold == model4), model4, $sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
